serdes_tx_framer: RTL and testbench

Transmit-side framer for the USRP2 SERDES link. It accepts 16-bit packet words over a valid/ready handshake and emits a continuous 16-bit word stream with per-byte K-character flags to the SERDES transmitter. Between packets it sends even-aligned comma pairs (K28.1, 0x3C in both bytes) so the far-end receiver can establish byte alignment. Each packet is delimited by SOP and EOP control words, and the block enforces a minimum idle gap between packets.

---
 rtl/serdes_pkg.sv | 25 ++
 rtl/serdes_crc16.sv | 59 +++++
 rtl/serdes_tx_framer.sv | 159 +++++++++++++++
 tb/tb_serdes_tx_framer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared SERDES link constants: K codes, framer state encoding, CRC-16 parameters
package serdes_pkg;

  // K-character codes; control words carry the same code in both bytes
  localparam logic [7:0] K_COMMA = 8'h3C;  // K28.1
  localparam logic [7:0] K_SOP   = 8'h5C;  // K28.2
  localparam logic [7:0] K_EOP   = 8'h7C;  // K28.3

  // Transmit framer state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOP  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CRC  = 3'd3;
  localparam logic [2:0] ST_EOP  = 3'd4;

  // CRC-16/CCITT-FALSE
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Even-aligned control word: same K code in both bytes
  function automatic logic [15:0] ctrl_word(input logic [7:0] k);
    return {k, k};
  endfunction

endpackage

// File: rtl/serdes_crc16.sv
// rtl/serdes_crc16.sv - CRC-16/CCITT-FALSE accumulator, 16 data bits per cycle, MSB first
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (loads CRC16_INIT)
//   init_i     in   reload CRC16_INIT
//   en_i       in   fold data_i into the accumulator
//   data_i     in   16-bit data word
//   crc_o      out  accumulated CRC
//   crc_next_o out  combinational next CRC of crc_o and data_i
module serdes_crc16
  import serdes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o,
  output logic [15:0] crc_next_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] nxt;

  // With data width equal to CRC width, XOR-ing the whole word in first and
  // then shifting 16 times is the same as feeding the bits one at a time.
  always_comb begin
    nxt = crc_q ^ data_i;
    for (int b = 0; b < 16; b++) begin
      if (nxt[15]) begin
        nxt = {nxt[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        nxt = {nxt[14:0], 1'b0};
      end
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o      = crc_q;
  assign crc_next_o = nxt;

endmodule

// File: rtl/serdes_tx_framer.sv
// rtl/serdes_tx_framer.sv - SERDES transmit framer: comma idle, SOP/data/[CRC]/EOP packets, minimum idle gap
// Optional CRC word: define SERDES_TX_CRC_EN.
// Ports:
//   ser_tx_clk_i  in   word clock
//   ser_tx_rst_i  in   synchronous active-high reset
//   enable_i      in   permits a new packet to start (sampled in IDLE)
//   din_i         in   packet data word
//   din_valid_i   in   din_i valid
//   din_last_i    in   din_i is the last word of the packet
//   din_ready_o   out  framer accepts din_i this cycle (high in DATA)
//   ser_t_o       out  registered word to the SERDES
//   ser_tklsb_o   out  ser_t_o[7:0] is a K-character
//   ser_tkmsb_o   out  ser_t_o[15:8] is a K-character
//   underrun_o    out  pulse aligned with a mid-packet fill comma
//   pkt_cnt_o     out  EOPs sent, wrapping
module serdes_tx_framer
  import serdes_pkg::*;
#(
  parameter int unsigned MIN_IDLE = 4
) (
  input  logic        ser_tx_clk_i,
  input  logic        ser_tx_rst_i,
  input  logic        enable_i,
  input  logic [15:0] din_i,
  input  logic        din_valid_i,
  input  logic        din_last_i,
  output logic        din_ready_o,
  output logic [15:0] ser_t_o,
  output logic        ser_tklsb_o,
  output logic        ser_tkmsb_o,
  output logic        underrun_o,
  output logic [15:0] pkt_cnt_o
);

  localparam logic [7:0] MIN_IDLE_W = 8'(MIN_IDLE);

  logic [2:0]  state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] ser_t_q, ser_t_d;
  logic        tklsb_q, tklsb_d;
  logic        tkmsb_q, tkmsb_d;
  logic        underrun_q, underrun_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  logic        xfer;

  assign din_ready_o = (state_q == ST_DATA);
  assign xfer        = din_valid_i && din_ready_o;

`ifdef SERDES_TX_CRC_EN
  logic        crc_init;
  logic [15:0] crc_val;
  logic [15:0] crc_next_unused;

  assign crc_init = (state_q == ST_SOP);

  serdes_crc16 u_crc (
    .clk        (ser_tx_clk_i),
    .rst        (ser_tx_rst_i),
    .init_i     (crc_init),
    .en_i       (xfer),
    .data_i     (din_i),
    .crc_o      (crc_val),
    .crc_next_o (crc_next_unused)
  );
`endif

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    ser_t_d    = ctrl_word(K_COMMA);
    tklsb_d    = 1'b1;
    tkmsb_d    = 1'b1;
    underrun_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;

    case (state_q)
      ST_IDLE: begin
        gap_d = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        // The comma loaded this cycle is the last one the gap needs once the
        // decremented count reaches zero, so exactly MIN_IDLE commas separate
        // an EOP from the following SOP.
        if (gap_d == 8'd0 && enable_i && din_valid_i) begin
          state_d = ST_SOP;
        end
      end

      ST_SOP: begin
        ser_t_d = ctrl_word(K_SOP);
        state_d = ST_DATA;
      end

      ST_DATA: begin
        if (din_valid_i) begin
          ser_t_d = din_i;
          tklsb_d = 1'b0;
          tkmsb_d = 1'b0;
          if (din_last_i) begin
`ifdef SERDES_TX_CRC_EN
            state_d = ST_CRC;
`else
            state_d = ST_EOP;
`endif
          end
        end else begin
          // Fill comma; the receiver discards commas inside a packet
          underrun_d = 1'b1;
        end
      end

`ifdef SERDES_TX_CRC_EN
      ST_CRC: begin
        ser_t_d = crc_val;
        tklsb_d = 1'b0;
        tkmsb_d = 1'b0;
        state_d = ST_EOP;
      end
`endif

      ST_EOP: begin
        ser_t_d   = ctrl_word(K_EOP);
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        gap_d     = MIN_IDLE_W;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ser_tx_clk_i) begin
    if (ser_tx_rst_i) begin
      state_q    <= ST_IDLE;
      gap_q      <= MIN_IDLE_W;
      ser_t_q    <= ctrl_word(K_COMMA);
      tklsb_q    <= 1'b1;
      tkmsb_q    <= 1'b1;
      underrun_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      ser_t_q    <= ser_t_d;
      tklsb_q    <= tklsb_d;
      tkmsb_q    <= tkmsb_d;
      underrun_q <= underrun_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign ser_t_o     = ser_t_q;
  assign ser_tklsb_o = tklsb_q;
  assign ser_tkmsb_o = tkmsb_q;
  assign underrun_o  = underrun_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// tb/tb_serdes_tx_framer.sv - directed self-checking bench for serdes_tx_framer
module tb_serdes_tx_framer;

  localparam int MIN_IDLE = 4;
`ifdef SERDES_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  // record = {word, tkmsb, tklsb, underrun}
  localparam logic [18:0] REC_COMMA = {16'h3C3C, 2'b11, 1'b0};
  localparam logic [18:0] REC_FILL  = {16'h3C3C, 2'b11, 1'b1};
  localparam logic [18:0] REC_SOP   = {16'h5C5C, 2'b11, 1'b0};
  localparam logic [18:0] REC_EOP   = {16'h7C7C, 2'b11, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic [15:0] ser_t;
  logic        tklsb;
  logic        tkmsb;
  logic        underrun;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int passed = 0;

  logic [15:0] words [0:7];
  logic        mon_en = 1'b0;
  logic [18:0] mrec[$];
  logic [15:0] mp[$];

  always #5 clk = ~clk;

  serdes_tx_framer #(.MIN_IDLE(MIN_IDLE)) dut (
    .ser_tx_clk_i (clk),
    .ser_tx_rst_i (rst),
    .enable_i     (enable),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_last_i   (din_last),
    .din_ready_o  (din_ready),
    .ser_t_o      (ser_t),
    .ser_tklsb_o  (tklsb),
    .ser_tkmsb_o  (tkmsb),
    .underrun_o   (underrun),
    .pkt_cnt_o    (pkt_cnt)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      mrec.push_back({ser_t, tkmsb, tklsb, underrun});
      mp.push_back(pkt_cnt);
    end
  end

  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int w = 0; w < n; w++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ words[w][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Reset, release, and start recording from the first post-reset cycle
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; din_last = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    mrec.delete();
    mp.delete();
    mon_en = 1'b1;
  endtask

  task automatic drive_pkt(input int n, input int gap_at, input int gap_len);
    int   i;
    int   cyc;
    int   gaps;
    logic xfer;
    i = 0; cyc = 0; gaps = 0;
    while (i < n && cyc < 200) begin
      @(negedge clk);
      din      = words[i];
      din_last = (i == n - 1);
      if (din_ready && i == gap_at && gaps < gap_len) begin
        din_valid = 1'b0;
        gaps++;
      end else begin
        din_valid = 1'b1;
      end
      xfer = din_valid && din_ready;
      @(posedge clk);
      if (xfer) i++;
      cyc++;
    end
    checks++;
    if (i != n) $display("FAIL drive_timeout: words sent %0d, required %0d", i, n);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ser_t, tkmsb, tklsb, din_ready, underrun, pkt_cnt} !== {16'h3C3C, 2'b11, 1'b0, 1'b0, 16'h0})
      $display("FAIL reset_values: got %h/%b%b/%b/%b/%h, required 3c3c/11/0/0/0000",
               ser_t, tkmsb, tklsb, din_ready, underrun, pkt_cnt);
    else passed++;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({ser_t, tkmsb, tklsb, din_ready, pkt_cnt} !== {16'h3C3C, 2'b11, 1'b0, 16'h0})
        $display("FAIL idle_disabled cycle %0d: got %h/%b%b/%b/%h, required 3c3c/11/0/0000",
                 c, ser_t, tkmsb, tklsb, din_ready, pkt_cnt);
      else passed++;
    end
  endtask

  task automatic test_basic();
    logic [18:0] exp_q[$];
    int s;
    do_reset();
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    exp_q.push_back(REC_SOP);
    exp_q.push_back({16'h1234, 3'b000});
    exp_q.push_back({16'h5678, 3'b000});
    exp_q.push_back({16'h9ABC, 3'b000});
    if (CRC_ON) exp_q.push_back({crc_ref(3), 3'b000});
    exp_q.push_back(REC_EOP);
    exp_q.push_back(REC_COMMA);
    drive_pkt(3, -1, 0);
    @(negedge clk); din_valid = 1'b0;
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    s = -1;
    foreach (mrec[j]) if (s < 0 && mrec[j] == REC_SOP) s = j;
    checks++;
    if (s != MIN_IDLE) $display("FAIL basic_lead_commas: got %0d, required %0d", s, MIN_IDLE);
    else passed++;
    if (s < 0) s = 0;
    for (int j = 0; j < s; j++) begin
      checks++;
      if (mrec[j] !== REC_COMMA) $display("FAIL basic_lead %0d: got %h, required %h", j, mrec[j], REC_COMMA);
      else passed++;
    end
    foreach (exp_q[j]) begin
      checks++;
      if (s + j >= mrec.size()) $display("FAIL basic_word %0d: got nothing, required %h", j, exp_q[j]);
      else if (mrec[s + j] !== exp_q[j]) $display("FAIL basic_word %0d: got %h, required %h", j, mrec[s + j], exp_q[j]);
      else passed++;
    end
    checks++;
    if (s + exp_q.size() - 2 >= mp.size()) $display("FAIL basic_pkt_cnt: got nothing, required 1");
    else if (mp[s + exp_q.size() - 2] !== 16'd1) $display("FAIL basic_pkt_cnt: got %0d, required 1", mp[s + exp_q.size() - 2]);
    else passed++;
  endtask

  task automatic test_underrun();
    logic [18:0] exp_q[$];
    int s;
    do_reset();
    words[0] = 16'hAAAA; words[1] = 16'h5555; words[2] = 16'h0F0F; words[3] = 16'hF0F0;
    exp_q.push_back(REC_SOP);
    exp_q.push_back({16'hAAAA, 3'b000});
    exp_q.push_back({16'h5555, 3'b000});
    exp_q.push_back(REC_FILL);
    exp_q.push_back(REC_FILL);
    exp_q.push_back({16'h0F0F, 3'b000});
    exp_q.push_back({16'hF0F0, 3'b000});
    if (CRC_ON) exp_q.push_back({crc_ref(4), 3'b000});
    exp_q.push_back(REC_EOP);
    exp_q.push_back(REC_COMMA);
    drive_pkt(4, 2, 2);
    @(negedge clk); din_valid = 1'b0;
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    s = -1;
    foreach (mrec[j]) if (s < 0 && mrec[j] == REC_SOP) s = j;
    checks++;
    if (s < 0) begin
      $display("FAIL underrun_sop: got none, required one");
      s = 0;
    end else passed++;
    foreach (exp_q[j]) begin
      checks++;
      if (s + j >= mrec.size()) $display("FAIL underrun_word %0d: got nothing, required %h", j, exp_q[j]);
      else if (mrec[s + j] !== exp_q[j]) $display("FAIL underrun_word %0d: got %h, required %h", j, mrec[s + j], exp_q[j]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp_q[$];
    int s;
    do_reset();
    words[0] = 16'h1111; words[1] = 16'h2222;
    exp_q.push_back(REC_SOP);
    exp_q.push_back({16'h1111, 3'b000});
    exp_q.push_back({16'h2222, 3'b000});
    if (CRC_ON) exp_q.push_back({crc_ref(2), 3'b000});
    exp_q.push_back(REC_EOP);
    for (int g = 0; g < MIN_IDLE; g++) exp_q.push_back(REC_COMMA);
    drive_pkt(2, -1, 0);
    words[0] = 16'h3333;
    exp_q.push_back(REC_SOP);
    exp_q.push_back({16'h3333, 3'b000});
    if (CRC_ON) exp_q.push_back({crc_ref(1), 3'b000});
    exp_q.push_back(REC_EOP);
    drive_pkt(1, -1, 0);
    @(negedge clk); din_valid = 1'b0;
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    s = -1;
    foreach (mrec[j]) if (s < 0 && mrec[j] == REC_SOP) s = j;
    checks++;
    if (s < 0) begin
      $display("FAIL b2b_sop: got none, required one");
      s = 0;
    end else passed++;
    foreach (exp_q[j]) begin
      checks++;
      if (s + j >= mrec.size()) $display("FAIL b2b_word %0d: got nothing, required %h", j, exp_q[j]);
      else if (mrec[s + j] !== exp_q[j]) $display("FAIL b2b_word %0d: got %h, required %h", j, mrec[s + j], exp_q[j]);
      else passed++;
    end
    checks++;
    if (s + exp_q.size() - 1 >= mp.size()) $display("FAIL b2b_pkt_cnt: got nothing, required 2");
    else if (mp[s + exp_q.size() - 1] !== 16'd2) $display("FAIL b2b_pkt_cnt: got %0d, required 2", mp[s + exp_q.size() - 1]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int s;
    int cyc;
    do_reset();
    mon_en = 1'b0;
    words[0] = 16'h4444; words[1] = 16'h5555;
    @(negedge clk);
    din = words[0]; din_valid = 1'b1; din_last = 1'b0;
    cyc = 0;
    while (!din_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!din_ready) $display("FAIL midrst_data: got ready 0, required 1");
    else passed++;
    @(negedge clk);
    din = words[1];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    checks++;
    if ({ser_t, tkmsb, tklsb, din_ready, pkt_cnt} !== {16'h3C3C, 2'b11, 1'b0, 16'h0})
      $display("FAIL midrst_out: got %h/%b%b/%b/%h, required 3c3c/11/0/0000",
               ser_t, tkmsb, tklsb, din_ready, pkt_cnt);
    else passed++;
    @(posedge clk);
    mrec.delete();
    mp.delete();
    mon_en = 1'b1;
    words[0] = 16'hBEEF;
    drive_pkt(1, -1, 0);
    @(negedge clk); din_valid = 1'b0;
    repeat (8) @(negedge clk);
    mon_en = 1'b0;
    s = -1;
    foreach (mrec[j]) if (s < 0 && mrec[j] == REC_SOP) s = j;
    checks++;
    if (s != MIN_IDLE) $display("FAIL midrst_lead_commas: got %0d, required %0d", s, MIN_IDLE);
    else passed++;
    if (s < 0) s = 0;
    for (int j = 0; j < s; j++) begin
      checks++;
      if (mrec[j] !== REC_COMMA || mp[j] !== 16'd0)
        $display("FAIL midrst_lead %0d: got %h cnt %0d, required %h cnt 0", j, mrec[j], mp[j], REC_COMMA);
      else passed++;
    end
    s = s + (CRC_ON ? 3 : 2);
    checks++;
    if (s >= mrec.size()) $display("FAIL midrst_eop: got nothing, required %h", REC_EOP);
    else if (mrec[s] !== REC_EOP || mp[s] !== 16'd1)
      $display("FAIL midrst_eop: got %h cnt %0d, required %h cnt 1", mrec[s], mp[s], REC_EOP);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; din = 16'h0; din_valid = 1'b0; din_last = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
